// File: rtl/accel_throttle_pkg.sv
// Shared types for the accelerator dispatch throttle: request payload, control state, counter width.
package accel_throttle_pkg;

   localparam int unsigned CNT_W        = 32;
   localparam int unsigned PAYLOAD_XLEN = 64;

   typedef struct packed {
      logic [31:0]             insn;
      logic [PAYLOAD_XLEN-1:0] rs1;
      logic [PAYLOAD_XLEN-1:0] rs2;
   } payload_t;

   localparam int unsigned PAYLOAD_W = $bits(payload_t);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_HALT
   } state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/accel_throttle_fifo.sv
// DEPTH-entry request payload FIFO; head is read straight from storage so a push is visible next cycle.
module accel_throttle_fifo
   import accel_throttle_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 push_i,
   input  logic [PAYLOAD_W-1:0] wdata_i,
   input  logic                 pop_i,
   output logic [PAYLOAD_W-1:0] rdata_o,
   output logic                 full_o,
   output logic                 empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [PAYLOAD_W-1:0] mem_q [DEPTH];
   logic [AW:0]          wr_ptr_q;
   logic [AW:0]          rd_ptr_q;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (push_i && !full_o) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
            wr_ptr_q                <= wr_ptr_q + 1'b1;
         end
         if (pop_i && !empty_o) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/accel_dispatch_throttle.sv
// Elastic dispatch stage to Ara capping in-flight instructions; build with ACCEL_THROTTLE_STATS_EN
// to add saturating stall counters.
module accel_dispatch_throttle
   import accel_throttle_pkg::*;
#(
   parameter int unsigned XLEN            = 64,
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned MAX_OUTSTANDING = 8,
   parameter int unsigned HALT_ON_EXC     = 1
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 in_valid_i,
   output logic                                 in_ready_o,
   input  logic [31:0]                          in_insn_i,
   input  logic [XLEN-1:0]                      in_rs1_i,
   input  logic [XLEN-1:0]                      in_rs2_i,
   output logic                                 out_valid_o,
   input  logic                                 out_ready_i,
   output logic [31:0]                          out_insn_o,
   output logic [XLEN-1:0]                      out_rs1_o,
   output logic [XLEN-1:0]                      out_rs2_o,
   input  logic                                 resp_valid_i,
   input  logic                                 resp_exc_i,
   output logic                                 resp_ready_o,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
   output logic [CNT_W-1:0]                     issued_cnt_o,
   output logic                                 exc_o,
   output logic                                 spurious_o,
`ifdef ACCEL_THROTTLE_STATS_EN
   output logic [CNT_W-1:0]                     stall_credit_cnt_o,
   output logic [CNT_W-1:0]                     stall_ready_cnt_o,
`endif
   output logic                                 drained_o
);

   localparam int unsigned OW = $clog2(MAX_OUTSTANDING+1);
   localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

   payload_t   in_payload;
   payload_t   head_payload;
   logic       push;
   logic       pop;
   logic       fifo_full;
   logic       fifo_empty;
   state_e     state_q;
   logic [OW-1:0]    out_cnt_q;
   logic [CNT_W-1:0] issued_q;
   logic       exc_q;
   logic       spur_q;

   always_comb begin
      in_payload      = '0;
      in_payload.insn = in_insn_i;
      in_payload.rs1  = PAYLOAD_XLEN'(in_rs1_i);
      in_payload.rs2  = PAYLOAD_XLEN'(in_rs2_i);
   end

   accel_throttle_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .wdata_i (in_payload),
      .pop_i   (pop),
      .rdata_o (head_payload),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Ready follows reset directly so upstream sees it low throughout reset.
   assign in_ready_o   = rst_ni & ~fifo_full;
   assign resp_ready_o = rst_ni;
   assign out_valid_o  = ~fifo_empty && (out_cnt_q < MAX_OUT) && (state_q == ST_RUN);
   assign push         = in_valid_i & in_ready_o;
   assign pop          = out_valid_o & out_ready_i;

   assign out_insn_o    = head_payload.insn;
   assign out_rs1_o     = head_payload.rs1[XLEN-1:0];
   assign out_rs2_o     = head_payload.rs2[XLEN-1:0];
   assign outstanding_o = out_cnt_q;
   assign issued_cnt_o  = issued_q;
   assign exc_o         = exc_q;
   assign spurious_o    = spur_q;
   assign drained_o     = fifo_empty && (out_cnt_q == '0) && !in_valid_i && (state_q != ST_IDLE);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         out_cnt_q <= '0;
         issued_q  <= '0;
         exc_q     <= 1'b0;
         spur_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: if (push) state_q <= ST_RUN;
            ST_RUN:  if ((HALT_ON_EXC != 0) && resp_valid_i && resp_exc_i) state_q <= ST_HALT;
            ST_HALT: state_q <= ST_HALT;
            default: state_q <= ST_IDLE;
         endcase

         // An issue and a response in the same cycle cancel out.
         if (pop && !resp_valid_i) begin
            out_cnt_q <= out_cnt_q + 1'b1;
         end else if (!pop && resp_valid_i && (out_cnt_q != '0)) begin
            out_cnt_q <= out_cnt_q - 1'b1;
         end

         if (pop) issued_q <= issued_q + 1'b1;
         if (resp_valid_i && resp_exc_i) exc_q <= 1'b1;
         if (resp_valid_i && (out_cnt_q == '0)) spur_q <= 1'b1;
      end
   end

`ifdef ACCEL_THROTTLE_STATS_EN
   logic [CNT_W-1:0] stall_credit_q;
   logic [CNT_W-1:0] stall_ready_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_credit_q <= '0;
         stall_ready_q  <= '0;
      end else begin
         if (!fifo_empty && (out_cnt_q == MAX_OUT) && (state_q == ST_RUN)) begin
            stall_credit_q <= sat_inc(stall_credit_q);
         end
         if (out_valid_o && !out_ready_i) begin
            stall_ready_q <= sat_inc(stall_ready_q);
         end
      end
   end

   assign stall_credit_cnt_o = stall_credit_q;
   assign stall_ready_cnt_o  = stall_ready_q;
`else
   // Stall statistics compiled out.
`endif

endmodule

// File: tb/tb_accel_dispatch_throttle.sv
// Cycle-table bench for accel_dispatch_throttle (MAX_OUTSTANDING=2, DEPTH=4) with a payload scoreboard.
module tb_accel_dispatch_throttle;

   localparam int XLEN = 64;

   typedef struct {
      bit          rst;
      bit          iv;
      logic [31:0] insn;
      bit          ordy;
      bit          rv;
      bit          rexc;
      bit          e_ir;
      bit          e_ov;
      logic [31:0] e_insn;
      int          e_out;
      int          e_iss;
      bit          e_exc;
      bit          e_spur;
      bit          e_drn;
   } vec_t;

   typedef struct {
      logic [31:0]     insn;
      logic [XLEN-1:0] rs1;
      logic [XLEN-1:0] rs2;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_ni = 1'b0;
   logic            in_valid_i = 1'b0;
   logic            in_ready_o;
   logic [31:0]     in_insn_i = '0;
   logic [XLEN-1:0] in_rs1_i = '0;
   logic [XLEN-1:0] in_rs2_i = '0;
   logic            out_valid_o;
   logic            out_ready_i = 1'b0;
   logic [31:0]     out_insn_o;
   logic [XLEN-1:0] out_rs1_o;
   logic [XLEN-1:0] out_rs2_o;
   logic            resp_valid_i = 1'b0;
   logic            resp_exc_i = 1'b0;
   logic            resp_ready_o;
   logic [1:0]      outstanding_o;
   logic [31:0]     issued_cnt_o;
   logic            exc_o;
   logic            spurious_o;
   logic            drained_o;
`ifdef ACCEL_THROTTLE_STATS_EN
   logic [31:0]     stall_credit_cnt_o;
   logic [31:0]     stall_ready_cnt_o;
`endif

   int n_cmp = 0;
   int n_err = 0;
   vec_t vecs[$];
   exp_t sb_q[$];

   always #5 clk = ~clk;

   accel_dispatch_throttle #(
      .XLEN            (XLEN),
      .DEPTH           (4),
      .MAX_OUTSTANDING (2),
      .HALT_ON_EXC     (1)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .in_valid_i    (in_valid_i),
      .in_ready_o    (in_ready_o),
      .in_insn_i     (in_insn_i),
      .in_rs1_i      (in_rs1_i),
      .in_rs2_i      (in_rs2_i),
      .out_valid_o   (out_valid_o),
      .out_ready_i   (out_ready_i),
      .out_insn_o    (out_insn_o),
      .out_rs1_o     (out_rs1_o),
      .out_rs2_o     (out_rs2_o),
      .resp_valid_i  (resp_valid_i),
      .resp_exc_i    (resp_exc_i),
      .resp_ready_o  (resp_ready_o),
      .outstanding_o (outstanding_o),
      .issued_cnt_o  (issued_cnt_o),
      .exc_o         (exc_o),
      .spurious_o    (spurious_o),
`ifdef ACCEL_THROTTLE_STATS_EN
      .stall_credit_cnt_o (stall_credit_cnt_o),
      .stall_ready_cnt_o  (stall_ready_cnt_o),
`endif
      .drained_o     (drained_o)
   );

   function automatic logic [XLEN-1:0] mk_rs1(input logic [31:0] insn);
      return {32'hCAFE_0000, insn};
   endfunction

   function automatic logic [XLEN-1:0] mk_rs2(input logic [31:0] insn);
      return {insn, 32'h5A5A_5A5A};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic row(input bit rst, input bit iv, input logic [31:0] insn, input bit ordy,
                      input bit rv, input bit rexc, input bit e_ir, input bit e_ov,
                      input logic [31:0] e_insn, input int e_out, input int e_iss,
                      input bit e_exc, input bit e_spur, input bit e_drn);
      vec_t v;
      v.rst = rst; v.iv = iv; v.insn = insn; v.ordy = ordy; v.rv = rv; v.rexc = rexc;
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_insn = e_insn; v.e_out = e_out; v.e_iss = e_iss;
      v.e_exc = e_exc; v.e_spur = e_spur; v.e_drn = e_drn;
      vecs.push_back(v);
   endtask

   initial begin
      // Three pushes with immediate responses, then a spurious response.
      //  rst iv insn      rdy rv ex | ir ov head      out iss exc spr drn
      row(1, 0, 32'h0,     1, 0, 0,   0, 0, 32'h0,     0, 0,  0, 0, 0);
      row(0, 1, 32'hA1,    1, 0, 0,   1, 0, 32'h0,     0, 0,  0, 0, 0);
      row(0, 1, 32'hA2,    1, 0, 0,   1, 1, 32'hA1,    0, 0,  0, 0, 0);
      row(0, 1, 32'hA3,    1, 1, 0,   1, 1, 32'hA2,    1, 1,  0, 0, 0);
      row(0, 0, 32'h0,     1, 1, 0,   1, 1, 32'hA3,    1, 2,  0, 0, 0);
      row(0, 0, 32'h0,     1, 1, 0,   1, 0, 32'h0,     1, 3,  0, 0, 0);
      row(0, 0, 32'h0,     1, 0, 0,   1, 0, 32'h0,     0, 3,  0, 0, 1);
      row(0, 0, 32'h0,     1, 1, 0,   1, 0, 32'h0,     0, 3,  0, 0, 1);
      row(0, 0, 32'h0,     1, 0, 0,   1, 0, 32'h0,     0, 3,  0, 1, 1);
      // Outstanding limit of 2 with four queued requests.
      row(1, 0, 32'h0,     1, 0, 0,   0, 0, 32'h0,     0, 0,  0, 0, 0);
      row(0, 1, 32'hB1,    1, 0, 0,   1, 0, 32'h0,     0, 0,  0, 0, 0);
      row(0, 1, 32'hB2,    1, 0, 0,   1, 1, 32'hB1,    0, 0,  0, 0, 0);
      row(0, 1, 32'hB3,    1, 0, 0,   1, 1, 32'hB2,    1, 1,  0, 0, 0);
      row(0, 1, 32'hB4,    1, 0, 0,   1, 0, 32'h0,     2, 2,  0, 0, 0);
      row(0, 0, 32'h0,     1, 0, 0,   1, 0, 32'h0,     2, 2,  0, 0, 0);
      row(0, 0, 32'h0,     1, 1, 0,   1, 0, 32'h0,     2, 2,  0, 0, 0);
      row(0, 0, 32'h0,     1, 0, 0,   1, 1, 32'hB3,    1, 2,  0, 0, 0);
      row(0, 0, 32'h0,     1, 0, 0,   1, 0, 32'h0,     2, 3,  0, 0, 0);
      // Back-pressure: five pushes into a 4-deep FIFO.
      row(1, 0, 32'h0,     0, 0, 0,   0, 0, 32'h0,     0, 0,  0, 0, 0);
      row(0, 1, 32'hC1,    0, 0, 0,   1, 0, 32'h0,     0, 0,  0, 0, 0);
      row(0, 1, 32'hC2,    0, 0, 0,   1, 1, 32'hC1,    0, 0,  0, 0, 0);
      row(0, 1, 32'hC3,    0, 0, 0,   1, 1, 32'hC1,    0, 0,  0, 0, 0);
      row(0, 1, 32'hC4,    0, 0, 0,   1, 1, 32'hC1,    0, 0,  0, 0, 0);
      row(0, 1, 32'hC5,    0, 0, 0,   0, 1, 32'hC1,    0, 0,  0, 0, 0);
      row(0, 1, 32'hC5,    0, 0, 0,   0, 1, 32'hC1,    0, 0,  0, 0, 0);
      row(0, 1, 32'hC5,    1, 0, 0,   0, 1, 32'hC1,    0, 0,  0, 0, 0);
      row(0, 1, 32'hC5,    1, 0, 0,   1, 1, 32'hC2,    1, 1,  0, 0, 0);
      row(0, 0, 32'h0,     1, 0, 0,   1, 0, 32'h0,     2, 2,  0, 0, 0);
      // Reset with two in flight; a late response is spurious. Then exception halt.
      row(1, 0, 32'h0,     1, 0, 0,   0, 0, 32'h0,     0, 0,  0, 0, 0);
      row(0, 0, 32'h0,     1, 1, 0,   1, 0, 32'h0,     0, 0,  0, 0, 0);
      row(0, 1, 32'hD1,    1, 0, 0,   1, 0, 32'h0,     0, 0,  0, 1, 0);
      row(0, 1, 32'hD2,    1, 0, 0,   1, 1, 32'hD1,    0, 0,  0, 1, 0);
      row(0, 1, 32'hD3,    1, 0, 0,   1, 1, 32'hD2,    1, 1,  0, 1, 0);
      row(0, 1, 32'hD4,    1, 1, 1,   1, 0, 32'h0,     2, 2,  0, 1, 0);
      row(0, 0, 32'h0,     1, 0, 0,   1, 0, 32'h0,     1, 2,  1, 1, 0);
      row(0, 0, 32'h0,     1, 1, 0,   1, 0, 32'h0,     1, 2,  1, 1, 0);
      row(0, 0, 32'h0,     1, 0, 0,   1, 0, 32'h0,     0, 2,  1, 1, 0);
      row(0, 1, 32'hD5,    1, 0, 0,   1, 0, 32'h0,     0, 2,  1, 1, 0);
      row(0, 1, 32'hD6,    1, 0, 0,   1, 0, 32'h0,     0, 2,  1, 1, 0);
      row(0, 1, 32'hD7,    1, 0, 0,   0, 0, 32'h0,     0, 2,  1, 1, 0);
      row(0, 0, 32'h0,     1, 0, 0,   0, 0, 32'h0,     0, 2,  1, 1, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         vec_t v;
         v = vecs[i];
         @(posedge clk);
         #1;
         rst_ni       = !v.rst;
         if (v.rst) sb_q.delete();
         in_valid_i   = v.iv;
         in_insn_i    = v.insn;
         in_rs1_i     = mk_rs1(v.insn);
         in_rs2_i     = mk_rs2(v.insn);
         out_ready_i  = v.ordy;
         resp_valid_i = v.rv;
         resp_exc_i   = v.rexc;
         @(negedge clk);

         chk($sformatf("r%0d in_ready", i), 64'(in_ready_o), 64'(v.e_ir));
         chk($sformatf("r%0d resp_ready", i), 64'(resp_ready_o), 64'(!v.rst));
         chk($sformatf("r%0d out_valid", i), 64'(out_valid_o), 64'(v.e_ov));
         chk($sformatf("r%0d outstanding", i), 64'(outstanding_o), 64'(v.e_out));
         chk($sformatf("r%0d issued", i), 64'(issued_cnt_o), 64'(v.e_iss));
         chk($sformatf("r%0d exc", i), 64'(exc_o), 64'(v.e_exc));
         chk($sformatf("r%0d spurious", i), 64'(spurious_o), 64'(v.e_spur));
         chk($sformatf("r%0d drained", i), 64'(drained_o), 64'(v.e_drn));
         if (v.e_ov) chk($sformatf("r%0d head_insn", i), 64'(out_insn_o), 64'(v.e_insn));
         if (v.rst) begin
            chk($sformatf("r%0d rst_insn", i), 64'(out_insn_o), 64'h0);
            chk($sformatf("r%0d rst_rs1", i), out_rs1_o, 64'h0);
         end

         // Scoreboard: expected payload queued on accepted push, checked on issue handshake.
         if (rst_ni && in_valid_i && in_ready_o) begin
            exp_t e;
            e.insn = in_insn_i; e.rs1 = in_rs1_i; e.rs2 = in_rs2_i;
            sb_q.push_back(e);
         end
         if (rst_ni && out_valid_o && out_ready_i) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL r%0d sb_issue: got insn %0h, expected no issue", i, out_insn_o);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk($sformatf("r%0d sb_insn", i), 64'(out_insn_o), 64'(e.insn));
               chk($sformatf("r%0d sb_rs1", i), out_rs1_o, e.rs1);
               chk($sformatf("r%0d sb_rs2", i), out_rs2_o, e.rs2);
            end
         end
         $display("row %0d: iv=%0b rdy=%0b rv=%0b ov=%0b insn=%0h out=%0d iss=%0d",
                  i, v.iv, v.ordy, v.rv, out_valid_o, out_insn_o, outstanding_o, issued_cnt_o);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/accel_dispatch_throttle.md
Name: accel_dispatch_throttle

Overview:
- Elastic stage between the instruction dispatcher (ideal trace dispatcher or CVA6 accelerator port) and Ara's accelerator request interface.
- Buffers request payloads (insn, rs1, rs2) in a small FIFO.
- Caps in-flight instructions (issued to Ara, response not yet returned) at MAX_OUTSTANDING.
- Counts issues and responses, raises sticky error flags and produces a drained indication that benches and the perf harness use as end-of-test.

Parameters:
- XLEN, 64, scalar operand width.
- DEPTH, 4, request FIFO entries; power of two, at least 2.
- MAX_OUTSTANDING, 8, maximum issued-but-unanswered instructions; at least 1.
- HALT_ON_EXC, 1, when 1, an exception response stops further issue.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  upstream request valid
- in_ready_o  out  1  upstream request ready
- in_insn_i  in  32  vector instruction
- in_rs1_i  in  XLEN  scalar operand 1
- in_rs2_i  in  XLEN  scalar operand 2
- out_valid_o  out  1  request valid to Ara
- out_ready_i  in  1  Ara req_ready
- out_insn_o  out  32  head instruction
- out_rs1_o  out  XLEN  head rs1
- out_rs2_o  out  XLEN  head rs2
- resp_valid_i  in  1  Ara response valid
- resp_exc_i  in  1  response carries exception
- resp_ready_o  out  1  always 1 after reset
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  in-flight count
- issued_cnt_o  out  32  total issued, wraps modulo 2^32
- exc_o  out  1  sticky, an exception response was seen
- spurious_o  out  1  sticky, a response arrived with outstanding==0
- drained_o  out  1  FIFO empty, outstanding==0, in_valid_i low, state not IDLE

Behaviour:
- Reset values:
  - All counters 0.
  - exc_o and spurious_o are 0.
  - out_valid_o is 0; out_* data are 0.
  - in_ready_o is 0 while in reset and 1 from the first cycle after reset.
  - resp_ready_o is 1 from the first cycle after reset.
  - State is IDLE.
- FIFO push and pop:
  - Push when in_valid_i && in_ready_o; in_ready_o = !full.
  - Pop occurs only on the out handshake.
  - No same-cycle pass-through while full: a push is refused when the FIFO is full, even if a pop happens in that cycle.
  - Latency is 1 cycle from push to the entry becoming visible on out_*.
  - Head data stay stable while out_valid_o && !out_ready_i.
- Issue gate:
  - out_valid_o = !empty && (outstanding_q < MAX_OUTSTANDING) && state==RUN.
  - The gate uses the registered count only, so a response arriving in the same cycle does not free a slot until the next cycle.
- Outstanding counter:
  - +1 on the out handshake; -1 on resp_valid_i.
  - Both in the same cycle: the counter holds.
  - resp_valid_i with the counter at 0: the counter stays 0 and spurious_o is set.
- issued_cnt_o increments on every out handshake.
- State machine:
  - IDLE -> RUN on the first push.
  - RUN -> HALT on resp_valid_i && resp_exc_i when HALT_ON_EXC=1.
  - HALT is terminal until reset. In HALT:
    - out_valid_o is 0.
    - The FIFO still accepts pushes until full.
    - Responses are still counted.
  - With HALT_ON_EXC=0, exceptions set exc_o only.
- drained_o is combinational from the registered state and in_valid_i.
- Reset asserted mid-operation discards FIFO contents and in-flight accounting immediately. Responses arriving later are counted as spurious.

Optional Feature:
- ACCEL_THROTTLE_STATS_EN adds the following 32-bit saturating counter outputs:
  - stall_credit_cnt_o: cycles blocked by the outstanding limit, i.e. !empty && outstanding_q == MAX_OUTSTANDING && state == RUN.
  - stall_ready_cnt_o: cycles where out_valid_o && !out_ready_i.
- Without the macro, these ports and their logic are absent.

Decomposition:
- Shared package accel_throttle_pkg holds:
  - the payload typedef (insn, rs1, rs2);
  - the state enum (IDLE, RUN, HALT);
  - the counter width constant.
- One sub-module, accel_throttle_fifo: a DEPTH-entry payload FIFO with full/empty outputs.

Test Plan:
- Reset, then push 3 instructions with out_ready_i=1 and immediate responses:
  - issued_cnt_o reaches 3.
  - outstanding_o returns to 0.
  - drained_o=1 on the cycle after the last response.
- MAX_OUTSTANDING=2, push 4 instructions, no responses:
  - Exactly 2 issued, outstanding_o=2, out_valid_o=0.
  - One response -> the third instruction issues on the following cycle.
- out_ready_i held 0, push 5 instructions with DEPTH=4:
  - in_ready_o drops after 4 accepts.
  - Head stays equal to instruction 1 until out_ready_i rises.
- resp_valid_i with outstanding=0:
  - spurious_o=1; outstanding_o stays 0.
- HALT_ON_EXC=1, two instructions in flight, first response carries resp_exc_i=1:
  - exc_o=1, state HALT, queued instructions are not issued.
  - The second response brings outstanding_o to 0.
- Issue handshake and response in the same cycle with outstanding=1:
  - outstanding_o stays 1; issued_cnt_o increments.
